// File: rtl/cq_eth_encap.sv
// cq_eth_encap: store-and-forward CQ TLPs into a packet buffer and emit each
// one as an Ethernet frame (16-byte header + payload) on a 64-bit byte-keyed stream.
module cq_eth_encap #(
  parameter int unsigned C_DATA_WIDTH  = 64,
  parameter int unsigned KEEP_WIDTH    = C_DATA_WIDTH/32,
  parameter int unsigned BUF_BEATS     = 512,
  parameter int unsigned MAX_TLP_BEATS = 64,
  parameter logic [47:0] DST_MAC       = 48'hFFFF_FFFF_FFFF,
  parameter logic [47:0] SRC_MAC       = 48'h0200_0000_0001,
  parameter logic [15:0] ETHERTYPE     = 16'h88B5
) (
  input  logic                      user_clk,
  input  logic                      cold_reset,
  input  logic [C_DATA_WIDTH-1:0]   s_axis_cq_tdata,
  input  logic [84:0]               s_axis_cq_tuser,
  input  logic [KEEP_WIDTH-1:0]     s_axis_cq_tkeep,
  input  logic                      s_axis_cq_tlast,
  input  logic                      s_axis_cq_tvalid,
  output logic                      s_axis_cq_tready,
  output logic [C_DATA_WIDTH-1:0]   m_axis_tx_tdata,
  output logic [C_DATA_WIDTH/8-1:0] m_axis_tx_tkeep,
  output logic                      m_axis_tx_tlast,
  output logic                      m_axis_tx_tvalid,
  input  logic                      m_axis_tx_tready,
  output logic [15:0]               tlp_count,
  output logic [15:0]               drop_count
);

  localparam int unsigned AW = $clog2(BUF_BEATS);
  localparam int unsigned CW = $clog2(MAX_TLP_BEATS + 1);
  localparam int unsigned LW = 2*CW + 1;
  localparam int unsigned MW = C_DATA_WIDTH + KEEP_WIDTH;

  typedef enum logic [1:0] {IDLE, HDR0, HDR1, PAYLOAD} state_t;

  state_t        state, state_nxt;
  logic [MW-1:0] buf_mem [BUF_BEATS];
  logic [MW-1:0] ram_q;
  logic [AW:0]   wr_spec, wr_commit, rd_ptr, used, free;
  logic [AW-1:0] rd_addr;
  logic          in_tlp, keep_q, can_accept, acc_now, wr_en, adv;
  logic [CW-1:0] beat_cnt, cnt_cur, cnt_nxt, rem_beats;
  logic [CW:0]   dw_cnt, len_dw;
  logic [LW-1:0] lf_mem [16];
  logic [LW-1:0] lf_din, lf_dout;
  logic [3:0]    lf_wp, lf_rp;
  logic [4:0]    lf_cnt;
  logic          lf_push, lf_pop, lf_full, lf_empty;
  logic [C_DATA_WIDTH/8-1:0] pay_keep;
  logic          unused_tuser;

  function automatic logic [63:0] be64(input logic [63:0] v);
    logic [63:0] r;
    for (int unsigned i = 0; i < 8; i++) r[8*i +: 8] = v[8*(7-i) +: 8];
    return r;
  endfunction

  assign s_axis_cq_tready = 1'b1;
  assign unused_tuser     = ^s_axis_cq_tuser;

  assign used       = wr_commit - rd_ptr;
  assign free       = (AW+1)'(BUF_BEATS) - used;
  assign lf_full    = (lf_cnt == 5'd16);
  assign lf_empty   = (lf_cnt == 5'd0);
  assign can_accept = (free >= (AW+1)'(MAX_TLP_BEATS)) && !lf_full;
  assign cnt_cur    = in_tlp ? beat_cnt : '0;
  assign cnt_nxt    = cnt_cur + CW'(1);
  assign acc_now    = in_tlp ? keep_q : can_accept;
  assign wr_en      = s_axis_cq_tvalid && acc_now;
  assign lf_push    = wr_en && s_axis_cq_tlast;
  assign dw_cnt     = {cnt_nxt, 1'b0} -
                      ((s_axis_cq_tkeep == KEEP_WIDTH'(1)) ? (CW+1)'(1) : (CW+1)'(0));
  assign lf_din     = {cnt_nxt, dw_cnt};
  assign lf_dout    = lf_mem[lf_rp];

  // Write side: accept decision on first beat, speculative write, commit on tlast.
  always_ff @(posedge user_clk or posedge cold_reset) begin
    if (cold_reset) begin
      in_tlp     <= 1'b0;
      keep_q     <= 1'b0;
      beat_cnt   <= '0;
      wr_spec    <= '0;
      wr_commit  <= '0;
      drop_count <= '0;
    end else if (s_axis_cq_tvalid) begin
      in_tlp   <= !s_axis_cq_tlast;
      beat_cnt <= cnt_nxt;
      if (!acc_now) begin
        keep_q <= 1'b0;
        if (s_axis_cq_tlast) drop_count <= drop_count + 16'd1;
      end else if (s_axis_cq_tlast) begin
        wr_spec   <= wr_spec + (AW+1)'(1);
        wr_commit <= wr_spec + (AW+1)'(1);
        keep_q    <= 1'b0;
      end else if (cnt_nxt == CW'(MAX_TLP_BEATS)) begin
        // oversize TLP: discard what was written and ignore the rest
        wr_spec <= wr_commit;
        keep_q  <= 1'b0;
      end else begin
        wr_spec <= wr_spec + (AW+1)'(1);
        keep_q  <= 1'b1;
      end
    end
  end

  // Packet RAM; read address looks one beat ahead so ram_q always holds buf[rd_ptr].
  always_ff @(posedge user_clk) begin
    if (wr_en) buf_mem[wr_spec[AW-1:0]] <= {s_axis_cq_tkeep, s_axis_cq_tdata};
    ram_q <= buf_mem[rd_addr];
  end

  // Length FIFO pointers.
  always_ff @(posedge user_clk or posedge cold_reset) begin
    if (cold_reset) begin
      lf_wp  <= '0;
      lf_rp  <= '0;
      lf_cnt <= '0;
    end else begin
      if (lf_push) lf_wp <= lf_wp + 4'd1;
      if (lf_pop)  lf_rp <= lf_rp + 4'd1;
      lf_cnt <= lf_cnt + {4'd0, lf_push} - {4'd0, lf_pop};
    end
  end

  // Length FIFO storage.
  always_ff @(posedge user_clk) begin
    if (lf_push) lf_mem[lf_wp] <= lf_din;
  end

  // Read FSM state and frame bookkeeping.
  always_ff @(posedge user_clk or posedge cold_reset) begin
    if (cold_reset) begin
      state     <= IDLE;
      rd_ptr    <= '0;
      rem_beats <= '0;
      len_dw    <= '0;
      tlp_count <= '0;
    end else begin
      state <= state_nxt;
      if (lf_pop) {rem_beats, len_dw} <= lf_dout;
      if (adv) begin
        rd_ptr    <= rd_ptr + (AW+1)'(1);
        rem_beats <= rem_beats - CW'(1);
        if (rem_beats == CW'(1)) tlp_count <= tlp_count + 16'd1;
      end
    end
  end

  // Read FSM next state and output stream.
  always_comb begin
    state_nxt        = state;
    lf_pop           = 1'b0;
    adv              = 1'b0;
    m_axis_tx_tdata  = '0;
    m_axis_tx_tkeep  = '0;
    m_axis_tx_tlast  = 1'b0;
    m_axis_tx_tvalid = 1'b0;
    pay_keep         = '0;
    for (int unsigned i = 0; i < KEEP_WIDTH; i++)
      pay_keep[4*i +: 4] = {4{ram_q[C_DATA_WIDTH+i]}};
    case (state)
      IDLE: begin
        if (!lf_empty) begin
          lf_pop    = 1'b1;
          state_nxt = HDR0;
        end
      end
      HDR0: begin
        m_axis_tx_tvalid = 1'b1;
        m_axis_tx_tkeep  = '1;
        m_axis_tx_tdata  = be64({DST_MAC, SRC_MAC[47:32]});
        if (m_axis_tx_tready) state_nxt = HDR1;
      end
      HDR1: begin
        m_axis_tx_tvalid = 1'b1;
        m_axis_tx_tkeep  = '1;
        m_axis_tx_tdata  = be64({SRC_MAC[31:0], ETHERTYPE, 16'(len_dw)});
        if (m_axis_tx_tready) state_nxt = PAYLOAD;
      end
      PAYLOAD: begin
        m_axis_tx_tvalid = 1'b1;
        m_axis_tx_tkeep  = pay_keep;
        m_axis_tx_tdata  = ram_q[C_DATA_WIDTH-1:0];
        m_axis_tx_tlast  = (rem_beats == CW'(1));
        if (m_axis_tx_tready) begin
          adv = 1'b1;
          if (rem_beats == CW'(1)) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign rd_addr = adv ? rd_ptr[AW-1:0] + AW'(1) : rd_ptr[AW-1:0];

endmodule

// File: tb/tb_cq_eth_encap.sv
// Scoreboard bench for cq_eth_encap: stimulus pushes expected frame beats,
// a negedge monitor pops and compares every accepted output beat.
module tb_cq_eth_encap;

  localparam logic [63:0] HDR0_EXP = 64'h0002_FFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [63:0] cq_tdata = '0;
  logic [84:0] cq_tuser = '0;
  logic [1:0]  cq_tkeep = '0;
  logic        cq_tlast = 1'b0;
  logic        cq_tvalid = 1'b0;
  logic        cq_tready;
  logic [63:0] tx_tdata;
  logic [7:0]  tx_tkeep;
  logic        tx_tlast;
  logic        tx_tvalid;
  logic        tx_tready = 1'b1;
  logic [15:0] tlp_count;
  logic [15:0] drop_count;

  int checks = 0;
  int failures = 0;
  int frames_seen = 0;
  int beat_in_frame = 0;
  int rdy_mode = 0;
  logic [72:0] exp_q[$];
  logic        prev_stall = 1'b0;
  logic [72:0] prev_beat = '0;

  cq_eth_encap dut (
    .user_clk(clk), .cold_reset(rst),
    .s_axis_cq_tdata(cq_tdata), .s_axis_cq_tuser(cq_tuser), .s_axis_cq_tkeep(cq_tkeep),
    .s_axis_cq_tlast(cq_tlast), .s_axis_cq_tvalid(cq_tvalid), .s_axis_cq_tready(cq_tready),
    .m_axis_tx_tdata(tx_tdata), .m_axis_tx_tkeep(tx_tkeep), .m_axis_tx_tlast(tx_tlast),
    .m_axis_tx_tvalid(tx_tvalid), .m_axis_tx_tready(tx_tready),
    .tlp_count(tlp_count), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // downstream ready pattern: 0 = always ready, 1 = toggle, 2 = held low
  initial begin
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       tx_tready = 1'b1;
        1:       tx_tready = !tx_tready;
        default: tx_tready = 1'b0;
      endcase
    end
  end

  // monitor: compare each accepted beat against the scoreboard, check stall hold
  always @(negedge clk) begin
    logic [72:0] act;
    logic [72:0] e;
    act = {tx_tlast, tx_tkeep, tx_tdata};
    if (rst) begin
      prev_stall    = 1'b0;
      beat_in_frame = 0;
    end else begin
      if (prev_stall) begin
        checks++;
        if (!tx_tvalid || act !== prev_beat) begin
          failures++;
          $display("FAIL stall_hold: got v=%0b %h required v=1 %h", tx_tvalid, act, prev_beat);
        end
      end
      if (tx_tvalid && tx_tready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_beat: got %h required none", act);
        end else begin
          e = exp_q.pop_front();
          if (act !== e) begin
            failures++;
            $display("FAIL beat: got %h required %h", act, e);
          end
        end
        beat_in_frame++;
        if (tx_tlast) begin
          frames_seen++;
          beat_in_frame = 0;
        end
      end
      prev_stall = tx_tvalid && !tx_tready;
      prev_beat  = act;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  function automatic logic [63:0] hdr1_exp(input logic [15:0] l);
    return {l[7:0], l[15:8], 48'hB588_0100_0000};
  endfunction

  function automatic logic [7:0] keep_exp(input logic [1:0] k);
    case (k)
      2'b11:   return 8'hFF;
      2'b01:   return 8'h0F;
      2'b10:   return 8'hF0;
      default: return 8'h00;
    endcase
  endfunction

  task automatic push_frame(input int n, input logic [63:0] base, input logic [1:0] lkeep);
    logic [15:0] l;
    logic [1:0]  k;
    l = 16'(2*n - ((lkeep == 2'b01) ? 1 : 0));
    exp_q.push_back({1'b0, 8'hFF, HDR0_EXP});
    exp_q.push_back({1'b0, 8'hFF, hdr1_exp(l)});
    for (int i = 0; i < n; i++) begin
      k = (i == n-1) ? lkeep : 2'b11;
      exp_q.push_back({(i == n-1), keep_exp(k), base + 64'(i)});
    end
  endtask

  task automatic send_tlp(input int n, input logic [63:0] base, input logic [1:0] lkeep, input bit fwd);
    if (fwd) push_frame(n, base, lkeep);
    for (int i = 0; i < n; i++) begin
      cq_tvalid = 1'b1;
      cq_tdata  = base + 64'(i);
      cq_tkeep  = (i == n-1) ? lkeep : 2'b11;
      cq_tlast  = (i == n-1);
      @(posedge clk); #1;
    end
    cq_tvalid = 1'b0;
    cq_tlast  = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int max_cyc);
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < max_cyc) begin
      @(posedge clk); #1;
      c++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_drain: got %0d beats pending required 0", name, exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int fs0;
    int g;
    #1 rst = 1'b1;
    #2;
    check("reset_tvalid", 64'(tx_tvalid), 64'd0);
    check("reset_tdata", tx_tdata, 64'd0);
    check("reset_tready", 64'(cq_tready), 64'd1);
    check("reset_counts", {32'd0, tlp_count, drop_count}, 64'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // single 3-beat TLP, odd dword count
    send_tlp(3, 64'h0001, 2'b01, 1'b1);
    wait_drain("t1", 50);
    check("t1_tlp_count", 64'(tlp_count), 64'd1);

    // same TLP under a toggling ready
    rdy_mode = 1;
    send_tlp(3, 64'h0001, 2'b01, 1'b1);
    wait_drain("t2", 100);
    rdy_mode = 0;
    check("t2_tlp_count", 64'(tlp_count), 64'd2);

    // oversize TLP dropped, following TLP forwarded
    fs0 = frames_seen;
    send_tlp(80, 64'h1000, 2'b11, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    check("t3_drop_count", 64'(drop_count), 64'd1);
    check("t3_no_frame", 64'(frames_seen - fs0), 64'd0);
    send_tlp(2, 64'h2000, 2'b11, 1'b1);
    wait_drain("t3", 50);
    check("t3_tlp_count", 64'(tlp_count), 64'd3);

    // fill the buffer with ready held low; the ninth TLP finds no room
    rdy_mode = 2;
    repeat (2) @(posedge clk);
    #1;
    fs0 = frames_seen;
    for (int t = 0; t < 8; t++) send_tlp(64, 64'h0050_0000 + 64'(t) * 64'h100, 2'b11, 1'b1);
    send_tlp(2, 64'h0060_0000, 2'b11, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    check("t4_drop_count", 64'(drop_count), 64'd2);
    check("t4_no_frame_yet", 64'(frames_seen - fs0), 64'd0);
    rdy_mode = 0;
    wait_drain("t4", 2000);
    check("t4_frames", 64'(frames_seen - fs0), 64'd8);
    check("t4_tlp_count", 64'(tlp_count), 64'd11);

    // 1000 one-beat TLPs, paced only by frames in flight
    fs0 = frames_seen;
    for (int i = 0; i < 1000; i++) begin
      g = 0;
      while ((i - (frames_seen - fs0)) >= 4 && g < 100) begin
        @(posedge clk); #1;
        g++;
      end
      if (g >= 100) begin
        checks++;
        failures++;
        $display("FAIL t5_stall: got %0d frames required progress", frames_seen - fs0);
        break;
      end
      send_tlp(1, 64'hC0DE_0000_0000_0000 + 64'(i) * 64'h0001_0003, (i % 2 == 1) ? 2'b11 : 2'b01, 1'b1);
    end
    wait_drain("t5", 200);
    check("t5_frames", 64'(frames_seen - fs0), 64'd1000);
    check("t5_tlp_count", 64'(tlp_count), 64'd1011);
    check("t5_drop_count", 64'(drop_count), 64'd2);

    // reset during the payload of frame 2 of 3
    fs0 = frames_seen;
    fork
      begin
        send_tlp(4, 64'h3000, 2'b11, 1'b1);
        send_tlp(4, 64'h3100, 2'b11, 1'b1);
        send_tlp(1, 64'h3200, 2'b11, 1'b0);
      end
      begin
        int w;
        w = 0;
        while (!(frames_seen == fs0 + 1 && beat_in_frame >= 3) && w < 200) begin
          @(negedge clk); #1;
          w++;
        end
        if (w >= 200) begin
          checks++;
          failures++;
          $display("FAIL t6_reach_payload: got %0d frames required 1", frames_seen - fs0);
        end
        @(posedge clk); #2;
        check("t6_tvalid_before", 64'(tx_tvalid), 64'd1);
        rst = 1'b1;
        #1;
        check("t6_tvalid_reset", 64'(tx_tvalid), 64'd0);
        check("t6_counts_reset", {32'd0, tlp_count, drop_count}, 64'd0);
        exp_q.delete();
      end
    join
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    send_tlp(2, 64'h4000, 2'b01, 1'b1);
    wait_drain("t6", 50);
    check("t6_tlp_count", 64'(tlp_count), 64'd1);
    check("t6_drop_count", 64'(drop_count), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
